// File: rtl/decode_stage_hz_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_hz_if
//  Description : Bundle of the decode-stage signals. The IF/ID-side inputs,
//                the writeback port, the pipeline controls and the ID/EX-side
//                outputs. The master modport drives the stage and the slave
//                modport is the decode stage itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_stage_hz_if #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int CW_W    = 15,
  parameter int ALUOP_W = 4
);
  // IF/ID side
  logic                id_valid;
  logic [XLEN-1:0]     ir_in;
  logic [XLEN-1:0]     pc_in;
  logic [XLEN-1:0]     npc_in;
  logic [XLEN-1:0]     imm_in;
  logic [CW_W-1:0]     cw_in;
  logic [ALUOP_W-1:0]  aluop_in;
  // pipeline control
  logic                flush;
  logic                ex_hold;
  // writeback port
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  // ID/EX side
  logic                stall_out;
  logic                ex_valid;
  logic [XLEN-1:0]     r1;
  logic [XLEN-1:0]     r2;
  logic [XLEN-1:0]     imm_out;
  logic [XLEN-1:0]     pc_out;
  logic [XLEN-1:0]     npc_out;
  logic [CW_W-3:0]     cw_exe;
  logic [ALUOP_W-1:0]  aluop_exe;
  logic [AW-1:0]       rd_exe;

  modport master (
    output id_valid, ir_in, pc_in, npc_in, imm_in, cw_in, aluop_in,
    output flush, ex_hold, wb_en, wb_addr, wb_data,
    input  stall_out, ex_valid, r1, r2, imm_out, pc_out, npc_out,
    input  cw_exe, aluop_exe, rd_exe
  );

  modport slave (
    input  id_valid, ir_in, pc_in, npc_in, imm_in, cw_in, aluop_in,
    input  flush, ex_hold, wb_en, wb_addr, wb_data,
    output stall_out, ex_valid, r1, r2, imm_out, pc_out, npc_out,
    output cw_exe, aluop_exe, rd_exe
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_hz.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_hz
//  Description : Instruction decode stage with integrated register file,
//                load-use hazard detection and an ID/EX pipeline register
//                supporting hold, bubble and flush with valid tracking.
//                Optional macro DECODE_RF_BYPASS_EN adds a write-through
//                bypass from the writeback port onto the read operands.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage_hz #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int CW_W      = 15,
  parameter int ALUOP_W   = 4,
  parameter int MEMRD_BIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  decode_stage_hz_if.slave  bus
);

  localparam int c_NREGS = 2 ** AW;

  // register file storage; entry 0 is never written and never read
  logic [XLEN-1:0]    r_rf [c_NREGS];

  // ID/EX pipeline register
  logic               r_ex_valid;
  logic [XLEN-1:0]    r_r1;
  logic [XLEN-1:0]    r_r2;
  logic [XLEN-1:0]    r_imm;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_npc;
  logic [CW_W-3:0]    r_cw;
  logic [ALUOP_W-1:0] r_aluop;
  logic [AW-1:0]      r_rd;

  // instruction fields and read enables
  logic [AW-1:0]      w_rs1;
  logic [AW-1:0]      w_rs2;
  logic [AW-1:0]      w_rd;
  logic               w_rd1_en;
  logic               w_rd2_en;
  logic [XLEN-1:0]    w_rf1;
  logic [XLEN-1:0]    w_rf2;
  logic [XLEN-1:0]    w_op1;
  logic [XLEN-1:0]    w_op2;
  logic               w_lu;
  logic               w_stall;
  logic               w_unused_ir;

  assign w_rs1    = bus.ir_in[15 +: AW];
  assign w_rs2    = bus.ir_in[20 +: AW];
  assign w_rd     = bus.ir_in[7 +: AW];
  assign w_rd1_en = bus.cw_in[CW_W-1];
  assign w_rd2_en = bus.cw_in[CW_W-2];

  // opcode/funct bits are decoded elsewhere; only the register fields matter here
  assign w_unused_ir = ^{bus.ir_in[XLEN-1:25], bus.ir_in[14:12], bus.ir_in[6:0]};

  // a disabled port and x0 both read as zero
  assign w_rf1 = (w_rd1_en && (w_rs1 != '0)) ? r_rf[w_rs1] : '0;
  assign w_rf2 = (w_rd2_en && (w_rs2 != '0)) ? r_rf[w_rs2] : '0;

`ifdef DECODE_RF_BYPASS_EN
  // same-cycle writeback overrides the stored value so WB->ID needs no gap
  assign w_op1 = (bus.wb_en && (bus.wb_addr == w_rs1) && (w_rs1 != '0) && w_rd1_en)
                 ? bus.wb_data : w_rf1;
  assign w_op2 = (bus.wb_en && (bus.wb_addr == w_rs2) && (w_rs2 != '0) && w_rd2_en)
                 ? bus.wb_data : w_rf2;
`else
  // without bypass the read returns the value stored before this edge's write
  assign w_op1 = w_rf1;
  assign w_op2 = w_rf2;
`endif

  // load in EX whose destination is a source of the instruction in ID
  assign w_lu = bus.id_valid && r_ex_valid && r_cw[MEMRD_BIT] && (r_rd != '0) &&
                ((w_rd1_en && (w_rs1 == r_rd)) || (w_rd2_en && (w_rs2 == r_rd)));

  // a flush kills the ID instruction, so fetch must not be held that cycle
  assign w_stall = !rst && !bus.flush && (bus.ex_hold || w_lu);

  // register file: clear on reset, write at the edge, x0 writes dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_addr != '0)) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // ID/EX register: reset, then flush, then hold, then load-use bubble, else capture
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_ex_valid <= 1'b0;
      r_r1       <= '0;
      r_r2       <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_npc      <= '0;
      r_cw       <= '0;
      r_aluop    <= '0;
      r_rd       <= '0;
    end else if (bus.ex_hold) begin
      r_ex_valid <= r_ex_valid;
    end else if (w_lu) begin
      r_ex_valid <= 1'b0;
      r_r1       <= '0;
      r_r2       <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_npc      <= '0;
      r_cw       <= '0;
      r_aluop    <= '0;
      r_rd       <= '0;
    end else begin
      r_ex_valid <= bus.id_valid;
      r_r1       <= w_op1;
      r_r2       <= w_op2;
      r_imm      <= bus.imm_in;
      r_pc       <= bus.pc_in;
      r_npc      <= bus.npc_in;
      // an empty slot carries no control so EX performs no side effects
      r_cw       <= bus.id_valid ? bus.cw_in[CW_W-3:0] : '0;
      r_aluop    <= bus.id_valid ? bus.aluop_in : '0;
      r_rd       <= bus.id_valid ? w_rd : '0;
    end
  end

  assign bus.stall_out = w_stall;
  assign bus.ex_valid  = r_ex_valid;
  assign bus.r1        = r_r1;
  assign bus.r2        = r_r2;
  assign bus.imm_out   = r_imm;
  assign bus.pc_out    = r_pc;
  assign bus.npc_out   = r_npc;
  assign bus.cw_exe    = r_cw;
  assign bus.aluop_exe = r_aluop;
  assign bus.rd_exe    = r_rd;

endmodule
`default_nettype wire
